// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage buffer and the core stage payloads.
// No logic; build option PIPE_SKID_EN selects the buffer depth in pipe_stage_buf.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [7:0]  ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [7:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_val;
        logic        wb_en;
    } mem_wb_t;

    localparam int PIPE_IF_ID_W  = $bits(if_id_t);
    localparam int PIPE_ID_EX_W  = $bits(id_ex_t);
    localparam int PIPE_EX_MEM_W = $bits(ex_mem_t);
    localparam int PIPE_MEM_WB_W = $bits(mem_wb_t);

    // Entry count is a pure function of the control state.
    function automatic logic [1:0] state_occ(input pipe_state_e s);
        case (s)
            EMPTY:   state_occ = 2'd0;
            BUSY:    state_occ = 2'd1;
            FULL:    state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_buf_ctrl.sv
// Control for pipe_stage_buf: state, in_ready, occ and payload load enables (no datapath).
// Latency 1 cycle; with PIPE_SKID_EN in_ready is registered, otherwise in_ready = !out_valid || out_ready.
// Flush forces EMPTY and suppresses every load in the same cycle.
module pipe_buf_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occ,
    output logic       load_main
`ifdef PIPE_SKID_EN
    ,
    output logic       load_skid,
    output logic       skid_to_main
`endif
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        accept;
    logic        drain;

    assign out_valid = (state_q != EMPTY);
    assign occ       = state_occ(state_q);
    assign drain     = out_valid && out_ready;
    assign accept    = in_valid && in_ready && !flush;

`ifdef PIPE_SKID_EN
    // Held in its own flop so in_ready has no path from out_ready.
    logic in_ready_q;
    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
`ifdef PIPE_SKID_EN
                    if (accept && !drain) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
`else
                    // Without skid an accept in BUSY implies a same-cycle drain.
                    if (accept) begin
                        load_main = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    if (drain) begin
                        state_d      = BUSY;
                        skid_to_main = 1'b1;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
`ifdef PIPE_SKID_EN
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifdef PIPE_SKID_EN
            in_ready_q <= (state_d != FULL);
`endif
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with synchronous flush; PIPE_SKID_EN adds a skid entry.
// Latency 1 cycle, one beat/cycle; backpressure: skid build has registered in_ready, else combinational.
// out_data comes only from the main register and holds while stalled unless flushed.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              load_main;
    logic [DATA_W-1:0] main_q;
`ifdef PIPE_SKID_EN
    logic              load_skid;
    logic              skid_to_main;
    logic [DATA_W-1:0] skid_q;
`endif

    pipe_buf_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .occ          (occ),
        .load_main    (load_main)
`ifdef PIPE_SKID_EN
        ,
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
            end
        end else if (load_main) begin
            main_q <= in_data;
`ifdef PIPE_SKID_EN
        end else if (skid_to_main) begin
            main_q <= skid_q;
`endif
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                skid_q <= '0;
            end
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end
`endif

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed vectors plus a seeded random stream.
// A second instance with CLEAR_ON_FLUSH = 0 shares all inputs to observe payload hold on flush.
module tb_pipe_stage_buf;

    localparam int DATA_W = 64;
`ifdef PIPE_SKID_EN
    localparam int FULL_OCC = 2;
`else
    localparam int FULL_OCC = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;
    logic              h_in_ready;
    logic              h_out_valid;
    logic [DATA_W-1:0] h_out_data;
    logic [1:0]        h_occ;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occ(occ)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(1'b0)) u_hold (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .occ(h_occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from just after a rising edge; returns just after the next rising edge.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (rst_n && iv && in_ready && !fl) exp_q.push_back(d);
        @(posedge clk);
        if (fl) exp_q.delete();
        #1;
    endtask

    initial begin : monitor
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid), 64'h1);
                    chk("stall_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_beat: got 0x%0h, expected no beat (t=%0t)", out_data, $time);
                    end else begin
                        chk("out_beat", out_data, exp_q.pop_front());
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_data  = out_data;
            end
        end
    end

    initial begin : driver
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_occ", 64'(occ), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;

        // Streaming: each beat visible the edge after it is accepted, no gaps.
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 64'(k), 1'b1, 1'b0);
            chk("stream_valid", 64'(out_valid), 64'h1);
            chk("stream_occ", 64'(occ), 64'h1);
            chk("stream_data", out_data, 64'(k));
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        chk("stream_drained_occ", 64'(occ), 64'h0);

        // Backpressure: 0xA held, 0xB either in skid or re-offered.
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        chk("bp_occ1", 64'(occ), 64'h1);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        chk("bp_occ_full", 64'(occ), 64'(FULL_OCC));
        chk("bp_in_ready", 64'(in_ready), 64'h0);
        chk("bp_hold_a", out_data, 64'hA);
        cycle(1'b1, 64'hB, 1'b1, 1'b0);
        chk("bp_next_b", out_data, 64'hB);
        chk("bp_occ_after", 64'(occ), 64'h1);
        chk("bp_in_ready_back", 64'(in_ready), 64'h1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        chk("bp_drained", 64'(occ), 64'h0);

        // Flush while full with a live input beat (0xC must never appear).
        cycle(1'b1, 64'hD, 1'b0, 1'b0);
        cycle(1'b1, 64'hE, 1'b0, 1'b0);
        chk("fl_pre_occ", 64'(occ), 64'(FULL_OCC));
        cycle(1'b1, 64'hC, 1'b0, 1'b1);
        chk("fl_out_valid", 64'(out_valid), 64'h0);
        chk("fl_occ", 64'(occ), 64'h0);
        chk("fl_clear_data", out_data, 64'h0);
        chk("fl_hold_valid", 64'(h_out_valid), 64'h0);
        chk("fl_hold_data", h_out_data, 64'hD);
        chk("fl_hold_occ", 64'(h_occ), 64'h0);
        chk("fl_in_ready", 64'(h_in_ready), 64'h1);

        // Flush coincident with a downstream transfer: 0x7 still counts as delivered.
        cycle(1'b1, 64'h7, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b1, 1'b1);
        chk("flx_occ", 64'(occ), 64'h0);
        chk("flx_valid", 64'(out_valid), 64'h0);

        // Asynchronous reset between edges.
        cycle(1'b1, 64'h11, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 1'b0, 1'b0);
        chk("ar_pre_occ", 64'(occ), 64'(FULL_OCC));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'h0);
        chk("ar_occ", 64'(occ), 64'h0);
        chk("ar_out_data", out_data, 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 64'h33, 1'b1, 1'b0);
        chk("ar_first_accept", out_data, 64'h33);
        chk("ar_first_occ", 64'(occ), 64'h1);

        // Random valid/ready with occasional flush; scoreboard enforces order and stability.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 64'(32'h1000 + i),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end
        repeat (3) cycle(1'b0, 64'h0, 1'b1, 1'b0);
        chk("end_queue_empty", 64'(exp_q.size()), 64'h0);
        chk("end_out_valid", 64'(out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
